// File: rtl/ca3_q5_bit_collector.sv
// Serial-to-parallel frame collector: shifts N bits LSB-first into a frame and
// hands completed frames to a one-slot output register with valid/ready handshake.
//
// state | meaning
// FILL  | fill_cnt < N, accepting serial bits
// FULL  | fill_cnt == N, output slot still occupied, transfer blocked
// XFER  | fill_cnt == N and output slot free, frame moves out on this edge
module ca3_q5_bit_collector #(
  parameter int N = 127
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         bit_ready,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [6:0]   fill_cnt,
  output logic [15:0]  frame_cnt
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_FULL = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [6:0] FILL_MAX = 7'(N);

  logic [N-1:0] shreg;
  logic [1:0]   state;
  logic         accept;
  logic         deliver;
  logic         xfer;

  // State is carried by fill_cnt; FULL vs XFER depends on the live output handshake.
  always_comb begin
    state = S_FILL;
    if (fill_cnt == FILL_MAX) begin
      state = (!word_valid || word_ready) ? S_XFER : S_FULL;
    end
  end

  assign bit_ready = (fill_cnt < FILL_MAX);
  assign accept    = bit_valid && bit_ready;
  assign deliver   = word_valid && word_ready;
  // A clear in the transfer cycle drops the full frame.
  assign xfer      = (state == S_XFER) && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg    <= '0;
      fill_cnt <= '0;
    end else if (clear) begin
      shreg    <= '0;
      fill_cnt <= '0;
    end else if (xfer) begin
      fill_cnt <= '0;
    end else if (accept) begin
      shreg    <= {bit_in, shreg[N-1:1]};
      fill_cnt <= fill_cnt + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (xfer) begin
        word_out   <= shreg;
        word_valid <= 1'b1;
      end else if (deliver) begin
        word_valid <= 1'b0;
      end
      if (deliver) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ca3_q5_bit_collector.sv
// Self-checking bench for ca3_q5_bit_collector: directed scenarios with a
// queue of expected frames pushed as bits are sent and popped on delivery.
module tb_ca3_q5_bit_collector;
  localparam int N = 127;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         clear = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         word_ready = 1'b0;
  logic         bit_ready;
  logic         word_valid;
  logic [N-1:0] word_out;
  logic [6:0]   fill_cnt;
  logic [15:0]  frame_cnt;

  int           checks = 0;
  int           passes = 0;
  logic [N-1:0] exp_q[$];
  logic [15:0]  exp_frames = 16'd0;

  always #5 clk = ~clk;

  ca3_q5_bit_collector #(.N(N)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .fill_cnt(fill_cnt), .frame_cnt(frame_cnt)
  );

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send_bit(input logic b);
    int guard = 0;
    bit_in = b;
    bit_valid = 1'b1;
    while (!bit_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      $display("FAIL send_bit_timeout bit_ready stuck at %0b, required 1", bit_ready);
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) send_bit(w[i]);
    exp_q.push_back(w);
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  task automatic test_reset();
    #12;
    checks++; if (fill_cnt !== 7'd0) $display("FAIL reset_fill got %0d exp 0", fill_cnt); else passes++;
    checks++; if (word_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", word_valid); else passes++;
    checks++; if (word_out !== '0) $display("FAIL reset_word got %h exp 0", word_out); else passes++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frames got %0d exp 0", frame_cnt); else passes++;
    checks++; if (bit_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", bit_ready); else passes++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] w;
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) w[i] = (i % 2 == 0);
    word_ready = 1'b1;
    send_frame(w);
    checks++; if (fill_cnt !== 7'd127) $display("FAIL basic_fill_full got %0d exp 127", fill_cnt); else passes++;
    checks++; if (bit_ready !== 1'b0) $display("FAIL basic_bubble_ready got %0b exp 0", bit_ready); else passes++;
    checks++; if (word_valid !== 1'b0) $display("FAIL basic_valid_early got %0b exp 0", word_valid); else passes++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (word_valid !== 1'b1) $display("FAIL basic_valid_rise got %0b exp 1", word_valid); else passes++;
    checks++; if (word_out !== e) $display("FAIL basic_word got %h exp %h", word_out, e); else passes++;
    checks++; if (word_out[1:0] !== 2'b01) $display("FAIL basic_bit_order got %b exp 01", word_out[1:0]); else passes++;
    checks++; if ($countones(word_out) != 64) $display("FAIL basic_popcount got %0d exp 64", $countones(word_out)); else passes++;
    checks++; if (fill_cnt !== 7'd0) $display("FAIL basic_fill_zero got %0d exp 0", fill_cnt); else passes++;
    @(negedge clk);
    exp_frames++;
    checks++; if (frame_cnt !== exp_frames) $display("FAIL basic_frames got %0d exp %0d", frame_cnt, exp_frames); else passes++;
    checks++; if (word_valid !== 1'b0) $display("FAIL basic_valid_drop got %0b exp 0", word_valid); else passes++;
    word_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] e;
    word_ready = 1'b0;
    send_frame(rand_word());
    @(negedge clk);
    send_frame(rand_word());
    bit_valid = 1'b1;
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    bit_valid = 1'b0;
    checks++; if (fill_cnt !== 7'd127) $display("FAIL bp_fill_stall got %0d exp 127", fill_cnt); else passes++;
    checks++; if (bit_ready !== 1'b0) $display("FAIL bp_ready got %0b exp 0", bit_ready); else passes++;
    checks++; if (word_valid !== 1'b1) $display("FAIL bp_valid_hold got %0b exp 1", word_valid); else passes++;
    checks++; if (word_out !== exp_q[0]) $display("FAIL bp_frame1_stable got %h exp %h", word_out, exp_q[0]); else passes++;
    word_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    exp_frames++;
    checks++; if (frame_cnt !== exp_frames) $display("FAIL bp_frames1 got %0d exp %0d", frame_cnt, exp_frames); else passes++;
    checks++; if (word_valid !== 1'b1) $display("FAIL bp_valid_stays got %0b exp 1", word_valid); else passes++;
    checks++; if (word_out !== exp_q[0]) $display("FAIL bp_frame2_loaded got %h exp %h", word_out, exp_q[0]); else passes++;
    @(negedge clk);
    e = exp_q.pop_front();
    exp_frames++;
    checks++; if (frame_cnt !== exp_frames) $display("FAIL bp_frames2 got %0d exp %0d", frame_cnt, exp_frames); else passes++;
    checks++; if (word_valid !== 1'b0) $display("FAIL bp_valid_drop got %0b exp 0", word_valid); else passes++;
    word_ready = 1'b0;
  endtask

  task automatic test_gapped();
    int acc = 0;
    int guard = 0;
    bit over = 1'b0;
    logic [N-1:0] e;
    word_ready = 1'b0;
    while (acc < N && guard < 4000) begin
      bit_in = 1'b1;
      bit_valid = 1'($urandom_range(0, 1));
      if (bit_valid && bit_ready) acc++;
      @(negedge clk);
      if (fill_cnt > 7'd127) over = 1'b1;
      guard++;
    end
    bit_valid = 1'b0;
    exp_q.push_back({N{1'b1}});
    checks++; if (acc != N) $display("FAIL gap_accept_timeout got %0d exp %0d", acc, N); else passes++;
    @(negedge clk);
    if (fill_cnt > 7'd127) over = 1'b1;
    e = exp_q.pop_front();
    checks++; if (word_valid !== 1'b1) $display("FAIL gap_valid got %0b exp 1", word_valid); else passes++;
    checks++; if (word_out !== e) $display("FAIL gap_word got %h exp %h", word_out, e); else passes++;
    checks++; if ($countones(word_out) != 127) $display("FAIL gap_popcount got %0d exp 127", $countones(word_out)); else passes++;
    checks++; if (over !== 1'b0) $display("FAIL gap_fill_bound got %0b exp 0", over); else passes++;
    word_ready = 1'b1;
    @(negedge clk);
    exp_frames++;
    checks++; if (frame_cnt !== exp_frames) $display("FAIL gap_frames got %0d exp %0d", frame_cnt, exp_frames); else passes++;
    word_ready = 1'b0;
  endtask

  task automatic test_clear();
    logic [N-1:0] e;
    word_ready = 1'b0;
    send_frame(rand_word());
    @(negedge clk);
    for (int i = 0; i < 50; i++) send_bit(1'($urandom_range(0, 1)));
    checks++; if (fill_cnt !== 7'd50) $display("FAIL clr_fill50 got %0d exp 50", fill_cnt); else passes++;
    clear = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bit_valid = 1'b0;
    checks++; if (fill_cnt !== 7'd0) $display("FAIL clr_fill0 got %0d exp 0", fill_cnt); else passes++;
    checks++; if (word_valid !== 1'b1) $display("FAIL clr_valid_kept got %0b exp 1", word_valid); else passes++;
    checks++; if (word_out !== exp_q[0]) $display("FAIL clr_word_kept got %h exp %h", word_out, exp_q[0]); else passes++;
    send_frame(rand_word());
    checks++; if (fill_cnt !== 7'd127) $display("FAIL clr_refill got %0d exp 127", fill_cnt); else passes++;
    word_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    exp_frames++;
    checks++; if (word_out !== exp_q[0]) $display("FAIL clr_next_frame got %h exp %h", word_out, exp_q[0]); else passes++;
    @(negedge clk);
    e = exp_q.pop_front();
    exp_frames++;
    checks++; if (frame_cnt !== exp_frames) $display("FAIL clr_frames got %0d exp %0d", frame_cnt, exp_frames); else passes++;
    word_ready = 1'b0;
    // Clear landing on the transfer cycle drops the frame.
    for (int i = 0; i < N; i++) send_bit(1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (word_valid !== 1'b0) $display("FAIL clr_drop_valid got %0b exp 0", word_valid); else passes++;
    checks++; if (fill_cnt !== 7'd0) $display("FAIL clr_drop_fill got %0d exp 0", fill_cnt); else passes++;
  endtask

  task automatic test_async_reset();
    logic [N-1:0] e;
    word_ready = 1'b0;
    send_frame(rand_word());
    @(negedge clk);
    for (int i = 0; i < 100; i++) send_bit(1'b1);
    checks++; if (fill_cnt !== 7'd100) $display("FAIL ar_fill100 got %0d exp 100", fill_cnt); else passes++;
    checks++; if (word_valid !== 1'b1) $display("FAIL ar_valid_pre got %0b exp 1", word_valid); else passes++;
    #2 rstn = 1'b0;
    #1;
    checks++; if (fill_cnt !== 7'd0) $display("FAIL ar_fill got %0d exp 0", fill_cnt); else passes++;
    checks++; if (word_valid !== 1'b0) $display("FAIL ar_valid got %0b exp 0", word_valid); else passes++;
    checks++; if (word_out !== '0) $display("FAIL ar_word got %h exp 0", word_out); else passes++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL ar_frames got %0d exp 0", frame_cnt); else passes++;
    checks++; if (bit_ready !== 1'b1) $display("FAIL ar_ready got %0b exp 1", bit_ready); else passes++;
    exp_q.delete();
    exp_frames = 16'd0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    word_ready = 1'b1;
    send_frame(rand_word());
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (word_out !== e) $display("FAIL ar_first_frame got %h exp %h", word_out, e); else passes++;
    @(negedge clk);
    exp_frames++;
    checks++; if (frame_cnt !== exp_frames) $display("FAIL ar_frames_after got %0d exp %0d", frame_cnt, exp_frames); else passes++;
    word_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [N-1:0] e;
    // Preload the delivered-frame count as if 65534 frames had already gone by.
    force dut.frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt;
    exp_frames = 16'hFFFE;
    @(negedge clk);
    checks++; if (frame_cnt !== exp_frames) $display("FAIL wrap_preload got %h exp %h", frame_cnt, exp_frames); else passes++;
    word_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_frame(rand_word());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (word_out !== e) $display("FAIL wrap_word got %h exp %h", word_out, e); else passes++;
      @(negedge clk);
      exp_frames++;
      checks++; if (frame_cnt !== exp_frames) $display("FAIL wrap_frames got %h exp %h", frame_cnt, exp_frames); else passes++;
    end
    checks++; if (frame_cnt !== 16'h0000) $display("FAIL wrap_zero got %h exp 0000", frame_cnt); else passes++;
    word_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_clear();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
